// File: rtl/pipeline_stall_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - ctrl_state_e : FSM state encoding (also exported on ctrl_state)
//   - ctrl_out_t   : bundle of per-stage enables/flushes produced each cycle
//   - CTRL_*       : canned output bundles for each kind of cycle
//   - NOP_INSTR    : instruction word the pipeline registers load on flush
// -----------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

   localparam int CTRL_STATE_W = 2;
   localparam int BUB_CNT_W    = 4;   // holds LOAD_USE_STALL_CYCLES-1 (0..14)

   typedef enum logic [CTRL_STATE_W-1:0] {
      S_RESET      = 2'd0,
      S_RUN        = 2'd1,
      S_LOAD_STALL = 2'd2,
      S_MEM_WAIT   = 2'd3
   } ctrl_state_e;

   // addi x0, x0, 0 : canonical NOP loaded by a flushed/bubbled register
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0]  OPC_JAL    = 7'b110_1111;

   typedef struct packed {
      logic pc_write;
      logic pc_sel_branch;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_flush;
      logic ex_mem_write;
      logic ex_mem_bubble;
      logic mem_wb_write;
   } ctrl_out_t;

   // Full freeze (reset, memory wait): nothing moves.
   localparam ctrl_out_t CTRL_IDLE = '0;

   localparam ctrl_out_t CTRL_RUN = '{
      pc_write: 1'b1, pc_sel_branch: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b0,
      id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
      ex_mem_bubble: 1'b0, mem_wb_write: 1'b1};

   // Redirect: younger IF/ID instructions are wrong-path, squash both.
   localparam ctrl_out_t CTRL_REDIRECT = '{
      pc_write: 1'b1, pc_sel_branch: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
      id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1,
      ex_mem_bubble: 1'b0, mem_wb_write: 1'b1};

   // Load-use bubble: front end holds, a NOP is slipped into EX_MEM.
   localparam ctrl_out_t CTRL_BUBBLE = '{
      pc_write: 1'b0, pc_sel_branch: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
      id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
      ex_mem_bubble: 1'b1, mem_wb_write: 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_if
// Hazard inputs and per-stage control outputs of the stall controller.
//   master : controller side (hazards in, enables/flushes out)
//   slave  : pipeline side   (hazards out, enables/flushes in)
// -----------------------------------------------------------------------------
interface pipeline_stall_controller_if;
   import pipeline_stall_controller_pkg::*;

   logic                    EX_stall;
   logic                    EX_branch_taken;
   logic                    imem_busy;
   logic                    dmem_busy;
   logic                    PC_write;
   logic                    PC_sel_branch;
   logic                    IF_ID_write;
   logic                    IF_ID_flush;
   logic                    ID_EX_write;
   logic                    ID_EX_flush;
   logic                    EX_MEM_write;
   logic                    EX_MEM_bubble;
   logic                    MEM_WB_write;
   logic [CTRL_STATE_W-1:0] ctrl_state;

   modport master (
      input  EX_stall, EX_branch_taken, imem_busy, dmem_busy,
      output PC_write, PC_sel_branch, IF_ID_write, IF_ID_flush, ID_EX_write,
             ID_EX_flush, EX_MEM_write, EX_MEM_bubble, MEM_WB_write, ctrl_state
   );

   modport slave (
      output EX_stall, EX_branch_taken, imem_busy, dmem_busy,
      input  PC_write, PC_sel_branch, IF_ID_write, IF_ID_flush, ID_EX_write,
             ID_EX_flush, EX_MEM_write, EX_MEM_bubble, MEM_WB_write, ctrl_state
   );
endinterface

// File: rtl/pipeline_stall_controller_perf_counter.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_perf_counter
// Saturating up-counter with enable.
//   clk, rst_n : clock, async active-low reset (clears count)
//   en_i       : count this cycle
//   cnt_o      : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipeline_stall_controller_perf_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central freeze/flush sequencer for the 5-stage pipeline. One decision per
// cycle, priority: memory wait > branch redirect > load-use stall > run.
// A taken branch seen together with EX_stall waits: its operands are not
// valid yet, so the redirect happens on the cycle the stall drops.
//
// Ports:
//   clk, rst_n        : clock, async active-low reset (-> S_RESET, all off)
//   ctl (master)      : hazard inputs, per-stage enables/flushes, ctrl_state
//   stall_cycle_count : bubble + memory-wait cycles    (PERF_COUNTERS_EN)
//   flush_count       : redirect cycles                (PERF_COUNTERS_EN)
// Parameters:
//   LOAD_USE_STALL_CYCLES : minimum bubbles per load-use hazard (1..15)
//   CNT_W                 : performance counter width
// Build option: define PERF_COUNTERS_EN to add the two saturating counters.
// -----------------------------------------------------------------------------
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int unsigned LOAD_USE_STALL_CYCLES = 1,
   parameter int unsigned CNT_W                 = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pipeline_stall_controller_if.master ctl
`ifdef PERF_COUNTERS_EN
   ,
   output logic [CNT_W-1:0]            stall_cycle_count,
   output logic [CNT_W-1:0]            flush_count
`endif
);
   localparam logic [BUB_CNT_W-1:0] STALL_RELOAD = BUB_CNT_W'(LOAD_USE_STALL_CYCLES - 1);

   ctrl_state_e          state_q, state_d, eff_state;
   logic [BUB_CNT_W-1:0] cnt_q, cnt_d;
   ctrl_out_t            out;
   logic                 busy;

   assign busy = ctl.imem_busy | ctl.dmem_busy;

   always_comb begin
      out     = CTRL_IDLE;
      state_d = state_q;
      cnt_d   = cnt_q;
      // Leaving a memory wait behaves exactly like the state it interrupted,
      // so the exit cycle already does useful work (no extra dead cycle).
      eff_state = state_q;
      if (state_q == S_MEM_WAIT)
         eff_state = (cnt_q != '0) ? S_LOAD_STALL : S_RUN;

      if (state_q == S_RESET) begin
         state_d = S_RUN;
      end else if (busy) begin
         // Full freeze; bubble counter is held so the stall resumes later.
         state_d = S_MEM_WAIT;
      end else if (ctl.EX_branch_taken && !ctl.EX_stall) begin
         out     = CTRL_REDIRECT;
         cnt_d   = '0;
         state_d = S_RUN;
      end else if (eff_state == S_LOAD_STALL) begin
         if (cnt_q != '0) begin
            out     = CTRL_BUBBLE;
            cnt_d   = cnt_q - 1'b1;
            state_d = ((cnt_q == BUB_CNT_W'(1)) && !ctl.EX_stall) ? S_RUN : S_LOAD_STALL;
         end else if (ctl.EX_stall) begin
            // Minimum served but hazard persists: keep bubbling at count 0.
            out     = CTRL_BUBBLE;
            state_d = S_LOAD_STALL;
         end else begin
            out     = CTRL_RUN;
            state_d = S_RUN;
         end
      end else if (ctl.EX_stall) begin
         out     = CTRL_BUBBLE;
         cnt_d   = STALL_RELOAD;
         state_d = (STALL_RELOAD != '0) ? S_LOAD_STALL : S_RUN;
      end else begin
         out     = CTRL_RUN;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ctl.PC_write      = out.pc_write;
   assign ctl.PC_sel_branch = out.pc_sel_branch;
   assign ctl.IF_ID_write   = out.if_id_write;
   assign ctl.IF_ID_flush   = out.if_id_flush;
   assign ctl.ID_EX_write   = out.id_ex_write;
   assign ctl.ID_EX_flush   = out.id_ex_flush;
   assign ctl.EX_MEM_write  = out.ex_mem_write;
   assign ctl.EX_MEM_bubble = out.ex_mem_bubble;
   assign ctl.MEM_WB_write  = out.mem_wb_write;
   assign ctl.ctrl_state    = state_q;

`ifdef PERF_COUNTERS_EN
   logic stall_evt, flush_evt;
   assign stall_evt = out.ex_mem_bubble | (busy & (state_q != S_RESET));
   assign flush_evt = out.pc_sel_branch;

   pipeline_stall_controller_perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (stall_evt),
      .cnt_o (stall_cycle_count)
   );

   pipeline_stall_controller_perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (flush_evt),
      .cnt_o (flush_count)
   );
`endif
endmodule
